// File: rtl/bidir_pattern_port_if.sv
// Control/status bundle between the protocol engine (master) and the
// bidirectional pattern port (slave). The pad-level inout line is kept
// outside the bundle and connects straight to the port.
interface bidir_pattern_port_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic             tx_oe_i;
    logic             run_i;
    logic [AW-1:0]    len_i;
    logic             wr_en_i;
    logic [AW-1:0]    wr_addr_i;
    logic [WIDTH-1:0] wr_data_i;
    logic [WIDTH-1:0] b_o;
    logic [AW-1:0]    idx_o;
    logic             drive_o;
    logic [WIDTH-1:0] rx_o;
    logic             rx_valid_o;

    modport master (
        output tx_oe_i, run_i, len_i, wr_en_i, wr_addr_i, wr_data_i,
        input  b_o, idx_o, drive_o, rx_o, rx_valid_o
    );

    modport slave (
        input  tx_oe_i, run_i, len_i, wr_en_i, wr_addr_i, wr_data_i,
        output b_o, idx_o, drive_o, rx_o, rx_valid_o
    );
endinterface

// File: rtl/bidir_pattern_port.sv
// Bidirectional pattern port: cycles a loadable pattern table onto a shared
// tri-state line while driving, or releases the line and captures it while
// listening. Every direction change passes through a one-cycle turnaround
// in which nobody is sampled and the port keeps the line released.
module bidir_pattern_port #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    bidir_pattern_port_if.slave  ctl,
    inout  wire  [WIDTH-1:0]     data_line_io
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        LISTEN  = 2'd0,
        TURN_TX = 2'd1,
        DRIVE   = 2'd2,
        TURN_RX = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic             rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0] table_q [DEPTH];
    logic [AW-1:0]    len_eff;
    logic             wr_ok;
    logic             drive;

    // Clamp the sequence length to the table and qualify table writes.
    always_comb begin
        len_eff = (int'(ctl.len_i) > DEPTH - 1) ? LAST_IDX : ctl.len_i;
        wr_ok   = ctl.wr_en_i && (int'(ctl.wr_addr_i) < DEPTH);
    end

    // Direction FSM next state, sequence index and receive capture.
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rx_d       = rx_q;
        rx_valid_d = 1'b0;
        case (state_q)
            LISTEN: begin
                rx_d       = data_line_io;
                rx_valid_d = 1'b1;
                if (ctl.tx_oe_i) state_d = TURN_TX;
            end
            TURN_TX: state_d = ctl.tx_oe_i ? DRIVE : LISTEN;
            DRIVE: begin
                if (ctl.run_i) idx_d = (idx_q >= len_eff) ? '0 : idx_q + 1'b1;
                if (!ctl.tx_oe_i) state_d = TURN_RX;
            end
            TURN_RX: state_d = ctl.tx_oe_i ? DRIVE : LISTEN;
            default: state_d = LISTEN;
        endcase
    end

    // Next pattern: a write to the entry being entered or held shows up at once.
    always_comb begin
        b_d = table_q[idx_d];
        if (wr_ok && (ctl.wr_addr_i == idx_d)) b_d = ctl.wr_data_i;
    end

    // State, index, pattern and receive registers.
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= LISTEN;
            idx_q      <= '0;
            b_q        <= '0;
            rx_q       <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            b_q        <= b_d;
            rx_q       <= rx_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Pattern table storage, writable in any state.
    // NOTE: the table is a small flop array, so it is cleared by reset like any other register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
        end else if (wr_ok) begin
            table_q[ctl.wr_addr_i] <= ctl.wr_data_i;
        end
    end

    // Output enable comes from the state register alone, so reset releases the line at once.
    assign drive          = (state_q == DRIVE);
    assign data_line_io   = drive ? b_q : {WIDTH{1'bz}};

    assign ctl.b_o        = b_q;
    assign ctl.idx_o      = idx_q;
    assign ctl.drive_o    = drive;
    assign ctl.rx_o       = rx_q;
    assign ctl.rx_valid_o = rx_valid_q;
endmodule

// File: tb/tb_bidir_pattern_port.sv
// Self-checking bench for bidir_pattern_port: directed scenarios plus
// randomized traffic against a direction/sequence reference model, and a
// second wider/deeper instance for the length-shrink wrap case.
module tb_bidir_pattern_port;
    localparam int W   = 8;
    localparam int D   = 4;
    localparam int AW  = $clog2(D);
    localparam int W2  = 16;
    localparam int D2  = 8;
    localparam int AW2 = $clog2(D2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          rst2;
    logic [W-1:0]  ext_val;
    wire  [W-1:0]  data_line;
    wire  [W2-1:0] data_line2;

    bidir_pattern_port_if #(.WIDTH(W),  .DEPTH(D))  u_if ();
    bidir_pattern_port_if #(.WIDTH(W2), .DEPTH(D2)) u_if2 ();

    bidir_pattern_port #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ctl          (u_if.slave),
        .data_line_io (data_line)
    );

    bidir_pattern_port #(.WIDTH(W2), .DEPTH(D2)) u_dut2 (
        .clk_i        (clk),
        .rst_i        (rst2),
        .ctl          (u_if2.slave),
        .data_line_io (data_line2)
    );

    // External agents drive the line whenever the port has released it.
    assign data_line  = u_if.drive_o  ? {W{1'bz}}  : ext_val;
    assign data_line2 = u_if2.drive_o ? {W2{1'bz}} : 16'h1234;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: direction is "granted side" plus a pending-turnaround flag.
    logic [W-1:0] m_tab [D];
    int           m_idx;
    logic [W-1:0] m_b;
    logic [W-1:0] m_rx;
    bit           m_rxv;
    bit           m_dir;   // 1 = drive side granted
    bit           m_turn;  // turnaround cycle in progress

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_tab[i] = '0;
        m_idx  = 0;
        m_b    = '0;
        m_rx   = '0;
        m_rxv  = 1'b0;
        m_dir  = 1'b0;
        m_turn = 1'b0;
    endtask

    function automatic bit m_driving();
        return m_dir && !m_turn;
    endfunction

    task automatic compare_all();
        bit exp_drv;
        exp_drv = m_driving();
        check("drive_o", u_if.drive_o, exp_drv);
        check("idx_o", u_if.idx_o, m_idx);
        check("b_o", u_if.b_o, m_b);
        check("rx_valid_o", u_if.rx_valid_o, m_rxv);
        check("rx_o", u_if.rx_o, m_rx);
        if (exp_drv) check("line", data_line, m_b);
    endtask

    // Advance the model by one clock using the inputs now applied, then clock the DUT and compare.
    task automatic step();
        int len_eff;
        int nidx;
        len_eff = (int'(u_if.len_i) > D - 1) ? D - 1 : int'(u_if.len_i);
        nidx    = m_idx;
        if (m_driving() && u_if.run_i) nidx = (m_idx >= len_eff) ? 0 : m_idx + 1;
        if (u_if.wr_en_i) m_tab[u_if.wr_addr_i] = u_if.wr_data_i;
        m_idx = nidx;
        m_b   = m_tab[nidx];
        if (!m_dir && !m_turn) begin
            m_rx  = ext_val;
            m_rxv = 1'b1;
        end else begin
            m_rxv = 1'b0;
        end
        if (m_turn) begin
            m_turn = 1'b0;
            m_dir  = u_if.tx_oe_i;
        end else if (u_if.tx_oe_i != m_dir) begin
            m_turn = 1'b1;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic rand_inputs();
        if ($urandom_range(0, 5) == 0) u_if.tx_oe_i = ~u_if.tx_oe_i;
        u_if.run_i = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) u_if.len_i = AW'($urandom_range(0, D - 1));
        u_if.wr_en_i   = ($urandom_range(0, 3) == 0);
        u_if.wr_addr_i = AW'($urandom_range(0, D - 1));
        u_if.wr_data_i = W'($urandom);
        ext_val        = W'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W-1:0]  load_tab [D];
        logic [W-1:0]  exp_seq  [6];
        logic [W2-1:0] tab2     [D2];

        load_tab = '{8'hF0, 8'h0F, 8'h3C, 8'hC3};
        exp_seq  = '{8'hF0, 8'h0F, 8'h3C, 8'hF0, 8'h0F, 8'h3C};

        u_if.tx_oe_i   = 1'b0;
        u_if.run_i     = 1'b0;
        u_if.len_i     = '0;
        u_if.wr_en_i   = 1'b0;
        u_if.wr_addr_i = '0;
        u_if.wr_data_i = '0;
        u_if2.tx_oe_i   = 1'b0;
        u_if2.run_i     = 1'b0;
        u_if2.len_i     = '0;
        u_if2.wr_en_i   = 1'b0;
        u_if2.wr_addr_i = '0;
        u_if2.wr_data_i = '0;
        ext_val = '0;
        rst  = 1'b1;
        rst2 = 1'b1;
        model_reset();

        // Reset state.
        #7;
        compare_all();
        #1 rst = 1'b0;

        // Listening: external A5 is captured one edge later.
        ext_val = 8'hA5;
        step();
        check("listen_rx", u_if.rx_o, 8'hA5);
        check("listen_rxv", u_if.rx_valid_o, 1'b1);
        check("listen_drive", u_if.drive_o, 1'b0);

        // Load the table while listening.
        for (int i = 0; i < D; i++) begin
            u_if.wr_en_i   = 1'b1;
            u_if.wr_addr_i = AW'(i);
            u_if.wr_data_i = load_tab[i];
            step();
        end
        u_if.wr_en_i = 1'b0;

        // Drive with len 2: one turnaround, then F0 0F 3C F0 0F 3C.
        u_if.len_i   = AW'(2);
        u_if.tx_oe_i = 1'b1;
        u_if.run_i   = 1'b1;
        step();
        check("turn_tx_drive", u_if.drive_o, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step();
            check("seq_line", data_line, exp_seq[k]);
        end

        // Drop direction: one released cycle, then captures resume.
        ext_val      = 8'h3E;
        u_if.tx_oe_i = 1'b0;
        u_if.run_i   = 1'b0;
        step();
        check("turn_rx_drive", u_if.drive_o, 1'b0);
        check("turn_rx_rxv", u_if.rx_valid_o, 1'b0);
        step();
        check("turn_rx_nocap", u_if.rx_valid_o, 1'b0);
        step();
        check("resume_rxv", u_if.rx_valid_o, 1'b1);
        check("resume_rx", u_if.rx_o, 8'h3E);

        // Back to drive: index held across the round trip.
        u_if.tx_oe_i = 1'b1;
        step();
        step();
        check("held_idx", u_if.idx_o, 2);
        check("held_line", data_line, 8'h3C);

        // Walk to idx 1, then write-through with and without advance.
        u_if.run_i = 1'b1;
        for (int g = 0; g < 8 && m_idx != 1; g++) step();
        check("reach_idx1", u_if.idx_o, 1);
        u_if.run_i     = 1'b0;
        u_if.wr_en_i   = 1'b1;
        u_if.wr_addr_i = AW'(1);
        u_if.wr_data_i = 8'h9A;
        step();
        check("wt_hold_b", u_if.b_o, 8'h9A);
        u_if.run_i     = 1'b1;
        u_if.wr_addr_i = AW'(2);
        u_if.wr_data_i = 8'h55;
        step();
        check("wt_adv_b", u_if.b_o, 8'h55);
        check("wt_adv_idx", u_if.idx_o, 2);
        u_if.wr_en_i = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            step();
        end

        // Asynchronous reset in the middle of a drive cycle.
        u_if.tx_oe_i = 1'b1;
        u_if.run_i   = 1'b1;
        u_if.wr_en_i = 1'b0;
        for (int g = 0; g < 4 && !m_driving(); g++) step();
        check("pre_rst_drive", u_if.drive_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_drive", u_if.drive_o, 1'b0);
        check("rst_async_idx", u_if.idx_o, 0);
        check("rst_async_b", u_if.b_o, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        u_if.len_i = AW'(D - 1);
        step();
        step();
        for (int k = 0; k < D; k++) begin
            step();
            check("tbl_cleared", u_if.b_o, 0);
        end

        for (int n = 0; n < 300; n++) begin
            rand_inputs();
            step();
        end

        // Wide/deep instance: len 7 -> 2 while at idx 5 wraps to 0.
        @(negedge clk);
        rst2 = 1'b0;
        for (int i = 0; i < D2; i++) tab2[i] = W2'(16'h1000 + i * 16'h0111);
        for (int i = 0; i < D2; i++) begin
            u_if2.wr_en_i   = 1'b1;
            u_if2.wr_addr_i = AW2'(i);
            u_if2.wr_data_i = tab2[i];
            @(posedge clk);
            #1;
        end
        u_if2.wr_en_i = 1'b0;
        check("d8_rx", u_if2.rx_o, 16'h1234);
        check("d8_rxv", u_if2.rx_valid_o, 1'b1);
        u_if2.len_i   = AW2'(7);
        u_if2.tx_oe_i = 1'b1;
        u_if2.run_i   = 1'b1;
        // TURN_TX, DRIVE at idx 0, then five advances.
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
        end
        check("d8_idx5", u_if2.idx_o, 5);
        check("d8_b5", u_if2.b_o, tab2[5]);
        check("d8_line5", data_line2, tab2[5]);
        u_if2.len_i = AW2'(2);
        @(posedge clk);
        #1;
        check("d8_wrap_idx", u_if2.idx_o, 0);
        check("d8_wrap_b", u_if2.b_o, tab2[0]);
        @(posedge clk);
        #1;
        check("d8_next_idx", u_if2.idx_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
